// File: rtl/instr_mem_access_pkg.sv
// Shared definitions for the RV32I memory-access stage: FSM states, opcode and
// funct3 codes, fault causes and the set of opcodes that write rd.
package instr_mem_access_pkg;

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    FC_MISALIGN = 2'd0,
    FC_BUS_ERR  = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_ILLEGAL  = 2'd3
  } fault_cause_e;

  function automatic logic writes_rd(input logic [6:0] opc);
    return opc inside {OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC,
                       OPC_JAL, OPC_JALR, OPC_SYSTEM};
  endfunction

endpackage

// File: rtl/instr_mem_access_load_align.sv
// Load data alignment: picks the byte/halfword lane addressed by addr[1:0]
// and sign- or zero-extends it according to funct3.
module mem_load_align
  import instr_mem_access_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      addr_lo_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (funct3_i)
      F3_B:    data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   data_o = {{(XLEN-16){1'b0}}, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/instr_mem_access.sv
// RV32I memory-access stage: passes ALU results to writeback, runs loads and
// stores over a req/ack bus with a timeout, and raises one-cycle faults.
module instr_mem_access
  import instr_mem_access_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_alu,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_stall,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [3:0]      o_dmem_be,
  output logic [XLEN-1:0] o_dmem_wdata,
  input  logic            i_dmem_ack,
  input  logic            i_dmem_err,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_wb_en,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause,
  output logic [XLEN-1:0] o_fault_addr
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic [4:0]      rd_q;
  logic [2:0]      f3_q;
  logic [XLEN-1:0] addr_q;
  logic            req_q, we_q;
  logic [3:0]      be_q;
  logic [XLEN-1:0] wdata_q;
  logic            wb_en_q, fault_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q, fault_addr_q;
  fault_cause_e    cause_q;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [4:0]      rd;
  logic            is_load, is_store, f3_legal, misaligned;
  logic [3:0]      be_d;
  logic [XLEN-1:0] wdata_d, ld_data;
  logic            unused_instr_bits;

  assign opc      = i_instr[6:0];
  assign rd       = i_instr[11:7];
  assign f3       = i_instr[14:12];
  assign is_load  = (opc == OPC_LOAD);
  assign is_store = (opc == OPC_STORE);
  assign f3_legal = is_load ? (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU})
                            : (f3 inside {F3_B, F3_H, F3_W});
  // Halfword codes share f3[1:0]=01, word is 10; byte accesses never misalign.
  assign misaligned = ((f3[1:0] == 2'b01) && i_alu[0]) ||
                      ((f3[1:0] == 2'b10) && (i_alu[1:0] != 2'b00));
  assign unused_instr_bits = ^i_instr[XLEN-1:15];

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = i_mem_data;
    if (is_store) begin
      case (f3)
        F3_B: begin
          be_d    = 4'b0001 << i_alu[1:0];
          wdata_d = {4{i_mem_data[7:0]}};
        end
        F3_H: begin
          be_d    = i_alu[1] ? 4'b1100 : 4'b0011;
          wdata_d = {2{i_mem_data[15:0]}};
        end
        default: ;
      endcase
    end
  end

  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata_i   (i_dmem_rdata),
    .addr_lo_i (addr_q[1:0]),
    .funct3_i  (f3_q),
    .data_o    (ld_data)
  );

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      rd_q         <= '0;
      f3_q         <= '0;
      addr_q       <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      be_q         <= '0;
      wdata_q      <= '0;
      wb_en_q      <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      fault_q      <= 1'b0;
      cause_q      <= FC_MISALIGN;
      fault_addr_q <= '0;
    end else begin
      wb_en_q <= 1'b0;
      fault_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_valid) begin
            if (!is_load && !is_store) begin
              wb_data_q <= i_alu;
              wb_rd_q   <= rd;
              wb_en_q   <= (rd != 5'd0) && writes_rd(opc);
            end else if (!f3_legal || misaligned) begin
              fault_q      <= 1'b1;
              cause_q      <= !f3_legal ? FC_ILLEGAL : FC_MISALIGN;
              fault_addr_q <= i_alu;
            end else begin
              rd_q    <= rd;
              f3_q    <= f3;
              addr_q  <= i_alu;
              req_q   <= 1'b1;
              we_q    <= is_store;
              be_q    <= be_d;
              wdata_q <= wdata_d;
              cnt_q   <= '0;
              state_q <= S_BUSY;
            end
          end
        end
        S_BUSY: begin
          if (i_dmem_err || i_dmem_ack || (cnt_q == CW'(TIMEOUT - 1))) begin
            req_q   <= 1'b0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            if (i_dmem_err || !i_dmem_ack) begin
              fault_q      <= 1'b1;
              cause_q      <= i_dmem_err ? FC_BUS_ERR : FC_TIMEOUT;
              fault_addr_q <= addr_q;
            end else if (!we_q) begin
              wb_en_q   <= (rd_q != 5'd0);
              wb_rd_q   <= rd_q;
              wb_data_q <= ld_data;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_stall       = (state_q == S_BUSY);
  assign o_dmem_req    = req_q;
  assign o_dmem_we     = we_q;
  assign o_dmem_addr   = {addr_q[XLEN-1:2], 2'b00};
  assign o_dmem_be     = be_q;
  assign o_dmem_wdata  = wdata_q;
  assign o_wb_en       = wb_en_q;
  assign o_wb_rd       = wb_rd_q;
  assign o_wb_data     = wb_data_q;
  assign o_fault       = fault_q;
  assign o_fault_cause = cause_q;
  assign o_fault_addr  = fault_addr_q;

endmodule

// File: tb/tb_instr_mem_access.sv
// Self-checking bench for instr_mem_access: scoreboard of writeback/fault
// strobes plus per-scenario inline checks of bus and stall behaviour.
module tb_instr_mem_access;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid;
  logic [31:0] instr, alu, mdata;
  logic        ack, err;
  logic [31:0] rdata;
  logic        o_stall, o_dmem_req, o_dmem_we;
  logic [31:0] o_dmem_addr, o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        o_wb_en, o_fault;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data, o_fault_addr;
  logic [1:0]  o_fault_cause;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic        is_fault;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  cause;
    logic [31:0] addr;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  instr_mem_access #(.XLEN(32), .TIMEOUT(TIMEOUT)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_instr(instr), .i_alu(alu),
    .i_mem_data(mdata), .o_stall(o_stall), .o_dmem_req(o_dmem_req),
    .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr), .o_dmem_be(o_dmem_be),
    .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(ack), .i_dmem_err(err),
    .i_dmem_rdata(rdata), .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd),
    .o_wb_data(o_wb_data), .o_fault(o_fault), .o_fault_cause(o_fault_cause),
    .o_fault_addr(o_fault_addr)
  );

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (o_wb_en || o_fault)) begin
      checks++;
      if (o_wb_en && o_fault) begin
        errors++;
        $display("FAIL strobe_both: wb_en=%b fault=%b, require exclusive", o_wb_en, o_fault);
      end else if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: wb_en=%b rd=%0d data=%h fault=%b cause=%0d, none expected",
                 o_wb_en, o_wb_rd, o_wb_data, o_fault, o_fault_cause);
      end else begin
        mon_e = sb.pop_front();
        if (mon_e.is_fault) begin
          if (!o_fault || o_fault_cause !== mon_e.cause || o_fault_addr !== mon_e.addr) begin
            errors++;
            $display("FAIL sb_fault: got fault=%b cause=%0d addr=%h, want cause=%0d addr=%h",
                     o_fault, o_fault_cause, o_fault_addr, mon_e.cause, mon_e.addr);
          end
        end else if (!o_wb_en || o_wb_rd !== mon_e.rd || o_wb_data !== mon_e.data) begin
          errors++;
          $display("FAIL sb_wb: got wb_en=%b rd=%0d data=%h, want rd=%0d data=%h",
                   o_wb_en, o_wb_rd, o_wb_data, mon_e.rd, mon_e.data);
        end
      end
    end
  end

  function automatic logic [31:0] mk_ld(input logic [2:0] f3, input logic [4:0] rd);
    return {17'd0, f3, rd, 7'b0000011};
  endfunction
  function automatic logic [31:0] mk_st(input logic [2:0] f3);
    return {17'd0, f3, 5'd0, 7'b0100011};
  endfunction
  function automatic logic [31:0] mk_op(input logic [6:0] opc, input logic [4:0] rd);
    return {20'd0, rd, opc};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] d);
    valid = 1'b1; instr = ins; alu = a; mdata = d;
  endtask

  task automatic idle_in();
    valid = 1'b0; instr = '0; alu = '0; mdata = '0;
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic [31:0] d);
    sb.push_back('{is_fault: 1'b0, rd: rd, data: d, cause: 2'd0, addr: 32'd0});
  endtask

  task automatic push_fault(input logic [1:0] c, input logic [31:0] a);
    sb.push_back('{is_fault: 1'b1, rd: 5'd0, data: 32'd0, cause: c, addr: a});
  endtask

  // Called in the first BUSY cycle: waits, then one cycle of response.
  task automatic reply(input int waits, input logic a, input logic e, input logic [31:0] rd);
    repeat (waits) step();
    ack = a; err = e; rdata = rd;
    step();
    ack = 1'b0; err = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_in();
    ack = 1'b0; err = 1'b0; rdata = '0;
    step(); step();
    checks++;
    if ({o_stall, o_dmem_req, o_dmem_we, o_wb_en, o_fault} !== 5'b0 ||
        o_dmem_addr !== 32'd0 || o_dmem_be !== 4'd0 || o_dmem_wdata !== 32'd0 ||
        o_wb_rd !== 5'd0 || o_wb_data !== 32'd0 || o_fault_cause !== 2'd0 ||
        o_fault_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b wb_en=%b fault=%b addr=%h be=%b wb_data=%h, want all 0",
               o_stall, o_dmem_req, o_wb_en, o_fault, o_dmem_addr, o_dmem_be, o_wb_data);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lw();
    int stall_cycles = 0;
    drive(mk_ld(3'b010, 5'd5), 32'h100, 32'd0);
    push_wb(5'd5, 32'hDEADBEEF);
    if (o_stall) stall_cycles++;
    step();                       // cycle 1: first req cycle
    idle_in();
    if (o_stall) stall_cycles++;
    checks++;
    if (o_dmem_req !== 1'b1 || o_dmem_we !== 1'b0 || o_dmem_addr !== 32'h100 || o_dmem_be !== 4'hF) begin
      errors++;
      $display("FAIL lw_bus: req=%b we=%b addr=%h be=%b, want 1 0 00000100 1111",
               o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be);
    end
    step();                       // cycle 2: registered memory acks
    if (o_stall) stall_cycles++;
    ack = 1'b1; rdata = 32'hDEADBEEF;
    step();                       // cycle 3: writeback
    ack = 1'b0;
    if (o_stall) stall_cycles++;
    checks++;
    if (o_wb_en !== 1'b1 || o_dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL lw_cycle3: wb_en=%b req=%b, want 1 0", o_wb_en, o_dmem_req);
    end
    checks++;
    if (stall_cycles != 2) begin
      errors++;
      $display("FAIL lw_stall_len: got %0d cycles, want 2", stall_cycles);
    end
    step();
  endtask

  task automatic test_loads();
    logic [2:0]  f3s  [7] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b000, 3'b000, 3'b001};
    logic [31:0] adrs [7] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h101, 32'h100};
    logic [31:0] exps [7] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                              32'h0000007F, 32'hFFFFFFFF, 32'hFFFFFF7F};
    for (int i = 0; i < 7; i++) begin
      drive(mk_ld(f3s[i], 5'(10 + i)), adrs[i], 32'd0);
      push_wb(5'(10 + i), exps[i]);
      step();
      idle_in();
      checks++;
      if (o_dmem_be !== 4'hF || o_dmem_addr !== {adrs[i][31:2], 2'b00} || o_dmem_req !== 1'b1) begin
        errors++;
        $display("FAIL load_bus[%0d]: be=%b addr=%h req=%b", i, o_dmem_be, o_dmem_addr, o_dmem_req);
      end
      reply(i % 2, 1'b1, 1'b0, 32'h80FFFF7F);
    end
    // rd=x0 load completes on the bus but must not strobe writeback.
    drive(mk_ld(3'b010, 5'd0), 32'h104, 32'd0);
    step();
    idle_in();
    reply(0, 1'b1, 1'b0, 32'h12345678);
    checks++;
    if (o_wb_en !== 1'b0) begin
      errors++;
      $display("FAIL load_x0: wb_en=%b, want 0", o_wb_en);
    end
    step();
  endtask

  task automatic test_store();
    logic [2:0]  f3s  [4] = '{3'b001, 3'b000, 3'b000, 3'b010};
    logic [31:0] adrs [4] = '{32'h106, 32'h101, 32'h103, 32'h108};
    logic [31:0] dats [4] = '{32'h1234ABCD, 32'h000000A5, 32'h7777773C, 32'hCAFEF00D};
    logic [3:0]  bes  [4] = '{4'b1100, 4'b0010, 4'b1000, 4'b1111};
    logic [31:0] wds  [4] = '{32'hABCDABCD, 32'hA5A5A5A5, 32'h3C3C3C3C, 32'hCAFEF00D};
    for (int i = 0; i < 4; i++) begin
      drive(mk_st(f3s[i]), adrs[i], dats[i]);
      step();
      idle_in();
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (o_dmem_req !== 1'b1 || o_dmem_we !== 1'b1 || o_dmem_be !== bes[i] ||
            o_dmem_wdata !== wds[i] || o_dmem_addr !== {adrs[i][31:2], 2'b00} || o_stall !== 1'b1) begin
          errors++;
          $display("FAIL store_bus[%0d] c%0d: req=%b we=%b be=%b wdata=%h addr=%h, want be=%b wdata=%h",
                   i, c, o_dmem_req, o_dmem_we, o_dmem_be, o_dmem_wdata, o_dmem_addr, bes[i], wds[i]);
        end
        if (c == 0) step();
      end
      reply(0, 1'b1, 1'b0, 32'hFFFFFFFF);
      checks++;
      if (o_wb_en !== 1'b0 || o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
        errors++;
        $display("FAIL store_done[%0d]: wb_en=%b req=%b stall=%b, want 0 0 0", i, o_wb_en, o_dmem_req, o_stall);
      end
    end
    step();
  endtask

  task automatic test_faults();
    logic [31:0] ins  [6] = '{mk_ld(3'b010, 5'd4), mk_ld(3'b001, 5'd4), mk_st(3'b010),
                              mk_st(3'b011), mk_ld(3'b110, 5'd4), mk_ld(3'b011, 5'd4)};
    logic [31:0] adrs [6] = '{32'h101, 32'h103, 32'h102, 32'h100, 32'h100, 32'h100};
    logic [1:0]  cs   [6] = '{2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3};
    for (int i = 0; i < 6; i++) begin
      drive(ins[i], adrs[i], 32'h55);
      push_fault(cs[i], adrs[i]);
      step();
      idle_in();
      checks++;
      if (o_fault !== 1'b1 || o_dmem_req !== 1'b0 || o_stall !== 1'b0 || o_wb_en !== 1'b0) begin
        errors++;
        $display("FAIL fault[%0d]: fault=%b req=%b stall=%b wb_en=%b, want 1 0 0 0",
                 i, o_fault, o_dmem_req, o_stall, o_wb_en);
      end
      step();
      checks++;
      if (o_fault !== 1'b0 || o_dmem_req !== 1'b0) begin
        errors++;
        $display("FAIL fault_pulse[%0d]: fault=%b req=%b, want 0 0", i, o_fault, o_dmem_req);
      end
    end
  endtask

  task automatic test_timeout_err();
    int n = 0;
    logic seen = 1'b0;
    drive(mk_ld(3'b010, 5'd6), 32'h200, 32'd0);
    push_fault(2'd2, 32'h200);
    step();
    idle_in();
    for (int i = 0; i < TIMEOUT + 8; i++) begin
      if (o_fault) begin
        seen = 1'b1;
        break;
      end
      if (o_dmem_req) n++;
      step();
    end
    checks++;
    if (!seen || n != TIMEOUT) begin
      errors++;
      $display("FAIL timeout: fault_seen=%b req_cycles=%0d, want 1 %0d", seen, n, TIMEOUT);
    end
    step();
    drive(mk_ld(3'b010, 5'd6), 32'h204, 32'd0);
    push_fault(2'd1, 32'h204);
    step();
    idle_in();
    reply(1, 1'b1, 1'b1, 32'h11111111);
    checks++;
    if (o_fault !== 1'b1 || o_wb_en !== 1'b0 || o_dmem_req !== 1'b0) begin
      errors++;
      $display("FAIL err_ack: fault=%b wb_en=%b req=%b, want 1 0 0", o_fault, o_wb_en, o_dmem_req);
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [6:0]  ops [4] = '{7'b0010011, 7'b0110011, 7'b0110111, 7'b1100011};
    logic [4:0]  rds [4] = '{5'd7, 5'd0, 5'd3, 5'd8};
    logic [3:0]  ens     = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      drive(mk_op(ops[i], rds[i]), 32'h1000 + 32'(i), 32'd0);
      if (ens[i]) push_wb(rds[i], 32'h1000 + 32'(i));
      step();
      checks++;
      if (o_wb_en !== ens[i] || o_stall !== 1'b0) begin
        errors++;
        $display("FAIL b2b_op[%0d]: wb_en=%b stall=%b, want %b 0", i, o_wb_en, o_stall, ens[i]);
      end
    end
    // Next op is held on the inputs while the load stalls.
    drive(mk_ld(3'b010, 5'd12), 32'h300, 32'd0);
    push_wb(5'd12, 32'h0BADF00D);
    push_wb(5'd9, 32'h55);
    step();
    drive(mk_op(7'b0010011, 5'd9), 32'h55, 32'd0);
    reply(1, 1'b1, 1'b0, 32'h0BADF00D);
    checks++;
    if (o_wb_en !== 1'b1 || o_wb_rd !== 5'd12 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL b2b_load_done: wb_en=%b rd=%0d stall=%b, want 1 12 0", o_wb_en, o_wb_rd, o_stall);
    end
    step();
    idle_in();
    checks++;
    if (o_wb_en !== 1'b1 || o_wb_rd !== 5'd9) begin
      errors++;
      $display("FAIL b2b_held_op: wb_en=%b rd=%0d, want 1 9", o_wb_en, o_wb_rd);
    end
    // Stray ack with no request outstanding.
    ack = 1'b1; rdata = 32'hFFFFFFFF;
    step();
    ack = 1'b0;
    step();
    checks++;
    if (o_wb_en !== 1'b0 || o_fault !== 1'b0 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: wb_en=%b fault=%b stall=%b, want 0 0 0", o_wb_en, o_fault, o_stall);
    end
  endtask

  task automatic test_reset_mid();
    drive(mk_ld(3'b010, 5'd14), 32'h400, 32'd0);
    step();
    idle_in();
    step(); step();               // third BUSY cycle
    rst_n = 1'b0;
    #1;
    checks++;
    if (o_dmem_req !== 1'b0 || o_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%b stall=%b, want 0 0", o_dmem_req, o_stall);
    end
    step();
    rst_n = 1'b1;
    step();
    drive(mk_ld(3'b010, 5'd15), 32'h404, 32'd0);
    push_wb(5'd15, 32'h600DCAFE);
    step();
    idle_in();
    reply(1, 1'b1, 1'b0, 32'h600DCAFE);
    checks++;
    if (o_wb_en !== 1'b1 || o_wb_data !== 32'h600DCAFE) begin
      errors++;
      $display("FAIL reset_mid_next: wb_en=%b data=%h, want 1 600dcafe", o_wb_en, o_wb_data);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_lw();
    test_loads();
    test_store();
    test_faults();
    test_timeout_err();
    test_back_to_back();
    test_reset_mid();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected strobes never seen, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
